// File: rtl/instr_encoder_loader.sv
// Packs opcode/offset/imm fields into 16-bit picoMIPS words and writes them sequentially
// into program memory, tracking the word count and an XOR checksum of the loaded image.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned MAX_OPCODE = 2
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        offset,
  input  logic [4:0]        imm,
  input  logic              in_last,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic [15:0]       checksum,
  output logic              done,
  output logic              error
);

  localparam logic [5:0] MaxOp = 6'(MAX_OPCODE);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [15:0]         csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;

  logic [15:0] word;
  logic        accept;
  logic        legal;
  logic        at_top;

  assign word     = {opcode, offset, imm};
  assign in_ready = (state_q == StLoad);
  assign accept   = in_valid & in_ready;
  assign legal    = (opcode <= MaxOp);
  assign at_top   = (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // start wins over a same-cycle handshake; that field set is dropped
    if (start) begin
      state_d = StLoad;
      addr_d  = '0;
      count_d = '0;
      csum_d  = '0;
    end else if (accept) begin
      if (!legal) begin
        state_d = StErr;
      end else begin
        we_d    = 1'b1;
        waddr_d = addr_q;
        wdata_d = word;
        count_d = count_q + 1'b1;
        csum_d  = csum_q ^ word;
        if (in_last) begin
          state_d = StDone;
        end else if (at_top) begin
          // last slot filled without in_last: overflow, address is not wrapped
          state_d = StErr;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign pm_we      = we_q;
  assign pm_addr    = waddr_q;
  assign pm_wdata   = wdata_q;
  assign word_count = count_q;
  assign checksum   = csum_q;
  assign done       = (state_q == StDone);
  assign error      = (state_q == StErr);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a 4-word memory so overflow is reachable.
module tb_instr_encoder_loader;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          start, in_valid, in_ready, in_last;
  logic [5:0]    opcode;
  logic [4:0]    offset, imm;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_wdata;
  logic [AW:0]   word_count;
  logic [15:0]   checksum;
  logic          done, error;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+15:0] sb[$];
  logic acc;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .MAX_OPCODE(2)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .offset(offset), .imm(imm), .in_last(in_last), .pm_we(pm_we),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .word_count(word_count), .checksum(checksum),
    .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected {addr, word}.
  initial begin
    logic [AW+15:0] e;
    forever begin
      @(negedge clk);
      if (n_reset && pm_we) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {14'd0, pm_addr, pm_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(pm_addr), 32'(e[AW+15:16]));
          check("wr_data", 32'(pm_wdata), 32'(e[15:0]));
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge. acc reports whether the handshake occurred.
  task automatic send(input logic [5:0] op, input logic [4:0] off, input logic [4:0] im,
                      input logic last, input logic wr, input logic [AW-1:0] ea,
                      input logic [15:0] ew, output logic got);
    opcode = op; offset = off; imm = im; in_last = last; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      #1;
      if (in_ready) begin
        got = 1'b1;
        if (wr) sb.push_back({ea, ew});
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_we"}, 32'(pm_we), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_addr"}, 32'(pm_addr), 0);
    check({tag, "_wdata"}, 32'(pm_wdata), 0);
    check({tag, "_count"}, 32'(word_count), 0);
    check({tag, "_csum"}, 32'(checksum), 0);
  endtask

  initial begin
    n_reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; offset = '0; imm = '0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    n_reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 0);

    // Encoding with negative offsets and a final word
    pulse_start();
    check("load_ready", 32'(in_ready), 1);
    send(6'd1, 5'h1E, 5'd0, 1'b0, 1'b1, 2'd0, 16'h07C0, acc); check("acc_e0", 32'(acc), 1);
    send(6'd1, 5'h1F, 5'd1, 1'b0, 1'b1, 2'd1, 16'h07E1, acc); check("acc_e1", 32'(acc), 1);
    send(6'd2, 5'h00, 5'd0, 1'b1, 1'b1, 2'd2, 16'h0800, acc); check("acc_e2", 32'(acc), 1);
    check("enc_done", 32'(done), 1);
    check("enc_error", 32'(error), 0);
    check("enc_count", 32'(word_count), 3);
    check("enc_csum", 32'(checksum), 32'h0821);
    check("enc_ready", 32'(in_ready), 0);

    // Illegal opcode
    pulse_start();
    check("ill_clr_count", 32'(word_count), 0);
    check("ill_clr_done", 32'(done), 0);
    send(6'd2, 5'h01, 5'd3, 1'b0, 1'b1, 2'd0, 16'h0823, acc); check("acc_i0", 32'(acc), 1);
    send(6'h3F, 5'h00, 5'd0, 1'b0, 1'b0, 2'd0, 16'h0000, acc); check("acc_i1", 32'(acc), 1);
    check("ill_error", 32'(error), 1);
    check("ill_done", 32'(done), 0);
    check("ill_count", 32'(word_count), 1);
    check("ill_csum", 32'(checksum), 32'h0823);
    check("ill_ready", 32'(in_ready), 0);

    // Overflow: fifth word must never be accepted
    pulse_start();
    send(6'd0, 5'h00, 5'd1, 1'b0, 1'b1, 2'd0, 16'h0001, acc); check("acc_o0", 32'(acc), 1);
    send(6'd0, 5'h00, 5'd2, 1'b0, 1'b1, 2'd1, 16'h0002, acc); check("acc_o1", 32'(acc), 1);
    send(6'd0, 5'h00, 5'd4, 1'b0, 1'b1, 2'd2, 16'h0004, acc); check("acc_o2", 32'(acc), 1);
    check("ovf_no_err_yet", 32'(error), 0);
    send(6'd0, 5'h00, 5'd8, 1'b0, 1'b1, 2'd3, 16'h0008, acc); check("acc_o3", 32'(acc), 1);
    check("ovf_error", 32'(error), 1);
    check("ovf_count", 32'(word_count), 4);
    check("ovf_csum", 32'(checksum), 32'h000F);
    send(6'd0, 5'h00, 5'd9, 1'b0, 1'b0, 2'd0, 16'h0000, acc); check("acc_o4", 32'(acc), 0);
    check("ovf_count_hold", 32'(word_count), 4);

    // Stalled stream, last word fills memory -> done
    pulse_start();
    send(6'd0, 5'h00, 5'd5, 1'b0, 1'b1, 2'd0, 16'h0005, acc); check("acc_s0", 32'(acc), 1);
    @(negedge clk);
    send(6'd1, 5'h03, 5'd0, 1'b0, 1'b1, 2'd1, 16'h0460, acc); check("acc_s1", 32'(acc), 1);
    @(negedge clk);
    send(6'd2, 5'h10, 5'd31, 1'b0, 1'b1, 2'd2, 16'h0A1F, acc); check("acc_s2", 32'(acc), 1);
    @(negedge clk);
    send(6'd0, 5'h0F, 5'd1, 1'b1, 1'b1, 2'd3, 16'h01E1, acc); check("acc_s3", 32'(acc), 1);
    check("stall_done", 32'(done), 1);
    check("stall_error", 32'(error), 0);
    check("stall_count", 32'(word_count), 4);
    check("stall_csum", 32'(checksum), 32'h0F9B);

    // start during LOAD with a valid field set
    pulse_start();
    send(6'd1, 5'h00, 5'd0, 1'b0, 1'b1, 2'd0, 16'h0400, acc); check("acc_r0", 32'(acc), 1);
    opcode = 6'd0; offset = 5'd0; imm = 5'd3; in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("rs_count", 32'(word_count), 0);
    check("rs_csum", 32'(checksum), 0);
    check("rs_ready", 32'(in_ready), 1);
    send(6'd0, 5'h00, 5'd7, 1'b1, 1'b1, 2'd0, 16'h0007, acc); check("acc_r1", 32'(acc), 1);
    check("rs_count2", 32'(word_count), 1);
    check("rs_csum2", 32'(checksum), 32'h0007);

    // Asynchronous reset mid-load, while a write strobe is active
    pulse_start();
    send(6'd0, 5'h00, 5'd1, 1'b0, 1'b1, 2'd0, 16'h0001, acc); check("acc_m0", 32'(acc), 1);
    #2 n_reset = 1'b0;
    #1 check_all_zero("mid");
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 0);
    check("post_rst_count", 32'(word_count), 0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
